// File: rtl/shift_register_universal.sv
// rtl/shift_register_universal.sv - universal shift register with burst engine (optional rotate/arith modes: SHIFT_REG_ROTATE_EN)
module shift_register_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             QL,
  output logic             QR,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROTR  = 3'b100;
  localparam logic [2:0] M_ROTL  = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [2:0]       cap_mode;
  logic [CNT_W-1:0] remaining;

  // Next register value for one step of the given operation.
  function automatic logic [WIDTH-1:0] step_value(
    input logic [2:0]       md,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] load_val,
    input logic             sr,
    input logic             sl
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (md)
      M_HOLD:  nxt = cur;
      M_SHR:   nxt = {sr, cur[WIDTH-1:1]};
      M_SHL:   nxt = {cur[WIDTH-2:0], sl};
      M_LOAD:  nxt = load_val;
`ifdef SHIFT_REG_ROTATE_EN
      M_ROTR:  nxt = {cur[0], cur[WIDTH-1:1]};
      M_ROTL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ASR:   nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
`endif
      M_CLEAR: nxt = '0;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Only true shift operations may be repeated by the burst engine.
  function automatic logic is_shift(input logic [2:0] md);
    logic ok;
    ok = (md == M_SHR) || (md == M_SHL);
`ifdef SHIFT_REG_ROTATE_EN
    ok = ok || (md == M_ROTR) || (md == M_ROTL) || (md == M_ASR);
`endif
    return ok;
  endfunction

  // Control FSM and data register; busy/done are registered alongside state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      q         <= '0;
      cap_mode  <= M_HOLD;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            cap_mode <= mode;
            if (count == '0 || !is_shift(mode)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              q <= step_value(mode, q, din, sin_r, sin_l);
              if (count == CNT_ONE) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state     <= RUN;
                busy      <= 1'b1;
                remaining <= count - CNT_ONE;
              end
            end
          end else if (en) begin
            q <= step_value(mode, q, din, sin_r, sin_l);
          end
        end
        RUN: begin
          q <= step_value(cap_mode, q, din, sin_r, sin_l);
          if (remaining == CNT_ONE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            remaining <= remaining - CNT_ONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = q;
  assign QL   = q[WIDTH-1];
  assign QR   = q[0];

endmodule

// File: tb/tb_shift_register_universal.sv
// tb/tb_shift_register_universal.sv - self-checking bench for shift_register_universal
module tb_shift_register_universal;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int MOD = 1 << W;

  logic          Clk;
  logic          Rst;
  logic [2:0]    mode;
  logic          en;
  logic          start;
  logic [CW-1:0] count;
  logic          sin_r;
  logic          sin_l;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          QL;
  logic          QR;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  // reference model: register value, steps still owed, burst op, done-cycle flag
  int m_q = 0;
  int m_left = 0;
  int m_mode = 0;
  bit m_done = 0;

  shift_register_universal #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .mode(mode), .en(en), .start(start), .count(count),
    .sin_r(sin_r), .sin_l(sin_l), .din(din), .dout(dout), .QL(QL), .QR(QR),
    .busy(busy), .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rot_en();
`ifdef SHIFT_REG_ROTATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int apply(input int md, input int v, input int sr, input int sl, input int ld);
    int half;
    half = MOD / 2;
    case (md)
      1: return v / 2 + sr * half;
      2: return (v * 2 + sl) % MOD;
      3: return ld;
      4: return rot_en() ? (v / 2 + (v % 2) * half) : v;
      5: return rot_en() ? ((v * 2) % MOD + v / half) : v;
      6: return rot_en() ? (v / 2 + (v >= half ? half : 0)) : v;
      7: return 0;
      default: return v;
    endcase
  endfunction

  function automatic bit shiftable(input int md);
    if (md == 1 || md == 2) return 1'b1;
    if (md >= 4 && md <= 6) return rot_en();
    return 1'b0;
  endfunction

  task automatic model_edge();
    if (Rst) begin
      m_q = 0; m_left = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_q = apply(m_mode, m_q, int'(sin_r), int'(sin_l), int'(din));
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (start) begin
      m_mode = int'(mode);
      if (count == 0 || !shiftable(m_mode)) begin
        m_done = 1;
      end else begin
        m_q = apply(m_mode, m_q, int'(sin_r), int'(sin_l), int'(din));
        m_left = int'(count) - 1;
        if (m_left == 0) m_done = 1;
      end
    end else if (en) begin
      m_q = apply(int'(mode), m_q, int'(sin_r), int'(sin_l), int'(din));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check("dout", 32'(dout), 32'(m_q));
    check("QL", 32'(QL), 32'((m_q / (MOD / 2)) % 2));
    check("QR", 32'(QR), 32'(m_q % 2));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic load(input logic [W-1:0] v);
    mode = 3'b011; en = 1'b1; start = 1'b0; din = v;
    tick();
    en = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    int done_cycles;
    Rst = 1'b1; mode = 3'b011; en = 1'b1; start = 1'b0; count = '0;
    sin_r = 1'b0; sin_l = 1'b0; din = 8'hFF;
    tick();
    tick();
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    Rst = 1'b0;

    load(8'hA5);
    check("load_a5_qr", 32'(QR), 32'h1);
    mode = 3'b001; en = 1'b1; sin_r = 1'b1;
    tick();
    check("shr_d2", 32'(dout), 32'hD2);
    check("shr_qr", 32'(QR), 32'h0);

    load(8'hA5);
    mode = 3'b010; en = 1'b1; sin_l = 1'b0;
    check("shl_ql0", 32'(QL), 32'h1);
    tick();
    check("shl_ql1", 32'(QL), 32'h0);
    tick();
    check("shl_ql2", 32'(QL), 32'h1);
    tick();
    check("shl_28", 32'(dout), 32'h28);
    en = 1'b0;

    load(8'h81);
    start = 1'b1; mode = 3'b001; count = 4'd4; sin_r = 1'b0;
    tick();
    start = 1'b0; mode = 3'b011; en = 1'b1; count = 4'd9;
    busy_cycles = 0; done_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cycles++;
        check("burst_dout", 32'(dout), 32'h08);
      end
      start = (i == 1);
      tick();
    end
    en = 1'b0; start = 1'b0;
    check("burst_busy_len", 32'(busy_cycles), 32'd3);
    check("burst_done_len", 32'(done_cycles), 32'd1);

    load(8'h3C);
    start = 1'b1; count = 4'd0; mode = 3'b001;
    tick();
    start = 1'b0;
    check("cnt0_done", 32'(done), 32'h1);
    check("cnt0_dout", 32'(dout), 32'h3C);
    tick();

    start = 1'b1; count = 4'd6; mode = 3'b010; sin_l = 1'b1;
    tick();
    start = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("abort_dout", 32'(dout), 32'h00);
    check("abort_done", 32'(done), 32'h0);
    for (int i = 0; i < 4; i++) tick();

`ifdef SHIFT_REG_ROTATE_EN
    load(8'h81);
    mode = 3'b101; en = 1'b1;
    tick();
    check("rotl_03", 32'(dout), 32'h03);
    load(8'h81);
    mode = 3'b110; en = 1'b1;
    tick();
    check("asr_c0", 32'(dout), 32'hC0);
`else
    load(8'h81);
    mode = 3'b101; en = 1'b1;
    tick();
    check("rotl_off_hold", 32'(dout), 32'h81);
    en = 1'b0; start = 1'b1; count = 4'd3;
    tick();
    start = 1'b0;
    check("rotl_off_done", 32'(done), 32'h1);
    check("rotl_off_burst", 32'(dout), 32'h81);
`endif
    en = 1'b0; start = 1'b0;
    tick();

    for (int i = 0; i < 400; i++) begin
      Rst   = ($urandom_range(0, 39) == 0);
      mode  = 3'($urandom_range(0, 7));
      en    = 1'($urandom);
      start = ($urandom_range(0, 5) == 0);
      count = CW'($urandom);
      sin_r = 1'($urandom);
      sin_l = 1'($urandom);
      din   = W'($urandom);
      tick();
    end
    Rst = 1'b0; start = 1'b0; en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
